sdf_butterfly_stage: RTL
========================

SDF_BUTTERFLY_STAGE -- requirements
Module: sdf_butterfly_stage

Interface
REQ-001 SHALL have parameter NBITS, default 12, sample width per component after rescale.
REQ-002 SHALL have parameter NBITScoeff, default 11, coefficient width of the upstream CSD multiplier.
REQ-003 SHALL have parameter NBITS_in, default NBITS+NBITScoeff+1, input component width.
REQ-004 SHALL have parameter DEPTH, default 8, delay-line length (half butterfly span); power of two, >=2.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-007 SHALL have port din  input  2*NBITS_in  upstream product, {real[MSB half], imag[LSB half]}, signed.
REQ-008 SHALL have port valid_in  input  1  din carries a sample this cycle.
REQ-009 SHALL have port dout  output  2*(NBITS+1)  butterfly result, {real, imag}, signed.
REQ-010 SHALL have port valid_out  output  1  dout valid this cycle.
REQ-011 SHALL have port sat_flag  output  1  sticky: a rescale saturated since reset.

Function
REQ-012 SHALL rescale each din component: add 2^(NBITScoeff-3), arithmetic shift right by NBITScoeff-2 (9 by default), i.e. round-half-up.
REQ-013 SHALL saturate each rescaled component to signed NBITS range [-2^(NBITS-1), 2^(NBITS-1)-1] and set sat_flag on any clamp of a valid sample.
REQ-014 SHALL keep a sample counter cnt, modulo 2*DEPTH, advancing only on valid_in; phase A = cnt<DEPTH, phase B = cnt>=DEPTH.
REQ-015 SHALL hold a DEPTH-entry FIFO delay line of complex NBITS+1-bit words; exactly one read and one write per valid_in, none otherwise.
REQ-016 Phase A: SHALL write the rescaled x (sign-extended) into the delay line and present the popped word d on dout.
REQ-017 Phase B: SHALL pop a, present a+x on dout, write a-x into the delay line; NBITS+1 result width makes overflow impossible.
REQ-018 SHALL register dout and valid_out; latency exactly 1 cycle from the valid_in beat.
REQ-019 SHALL keep a primed flag, set when the first phase-B beat is accepted; phase-A outputs SHALL assert valid_out only when primed, phase-B outputs always.
REQ-020 With valid_in low, SHALL drive valid_out low next cycle and hold dout, cnt, delay line unchanged; gaps of any length are transparent.
REQ-021 cnt wrap from 2*DEPTH-1 to 0 SHALL occur on the valid beat with no idle cycle; back-to-back blocks stream continuously.
REQ-022 No backpressure: every valid_in beat is consumed.

Reset
REQ-023 On rst=0, asynchronously: dout=0, valid_out=0, sat_flag=0, cnt=0, primed=0.
REQ-024 Delay-line contents need not be cleared; stale entries SHALL never reach valid_out because primed is cleared.
REQ-025 Reset mid-block SHALL discard the partial block; first valid_in after release is treated as cnt=0.
REQ-026 Release of rst SHALL take effect on the next rising clk edge; no output activity during reset.

Verification (DEPTH=8, NBITS=12, NBITScoeff=11)
REQ-027 Rescale: din real=51200, imag=-51200 -> internal 100/-100; real=256 -> 1; real=-256 -> 0; real=255 -> 0.
REQ-028 Saturation: din real=2048*512 -> clamps to 2047, sat_flag=1 until reset; real=-2049*512 -> -2048.
REQ-029 First block: real=k*512, imag=0, k=0..15 continuous -> valid_out low for beats 0..7, then real 8,10,...,22, imag 0, one cycle after beats 8..15.
REQ-030 Second block immediately after: any 8 samples -> 8 outputs real=-8, imag=0 (stored a-x), then next phase B continues.
REQ-031 Gaps: same first block with valid_in toggling 1/0 -> identical dout sequence, valid_out pulses only after valid beats.
REQ-032 Reset at beat 5 of block, then restart -> no valid_out for first 8 new beats; results match REQ-029 exactly.

Source files
------------

// File: rtl/sdf_butterfly_stage.sv
// Single-path delay-feedback (SDF) radix-2 butterfly stage.
// Rescales the upstream CSD product (round-half-up, saturate to NBITS), then
// runs a DEPTH-deep delay-line butterfly: phase A stores x and emits the word
// fed back from the previous block; phase B emits a+x and stores a-x.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   din        {real, imag} signed product, NBITS_in bits per component
//   valid_in   din carries a sample this cycle
//   dout       {real, imag} signed butterfly result, NBITS+1 bits per component
//   valid_out  dout holds a valid result this cycle
//   sat_flag   sticky, set when a valid sample was clamped during rescale
module sdf_butterfly_stage #(
    parameter int NBITS      = 12,
    parameter int NBITScoeff = 11,
    parameter int NBITS_in   = NBITS + NBITScoeff + 1,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*NBITS_in-1:0]     din,
    input  logic                      valid_in,
    output logic [2*(NBITS+1)-1:0]    dout,
    output logic                      valid_out,
    output logic                      sat_flag
);

    localparam int unsigned SHIFT = NBITScoeff - 2;
    localparam int unsigned WS    = NBITS_in + 1;   // headroom for the rounding add
    localparam int unsigned WO    = NBITS + 1;      // butterfly word width
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;         // counts 0 .. 2*DEPTH-1

    localparam logic [WS-1:0]        RND  = WS'(1) << (NBITScoeff - 3);
    localparam logic signed [WS-1:0] SMAX = WS'((2 ** (NBITS - 1)) - 1);
    localparam logic signed [WS-1:0] SMIN = WS'(-(2 ** (NBITS - 1)));

    // Round-half-up rescale with saturation; returns {clamped, value}.
    function automatic logic [NBITS:0] rescale(input logic [NBITS_in-1:0] v);
        logic signed [WS-1:0] sum;
        logic signed [WS-1:0] sh;
        sum = $signed({v[NBITS_in-1], v}) + $signed(RND);
        sh  = sum >>> SHIFT;
        if (sh > SMAX)
            rescale = {1'b1, SMAX[NBITS-1:0]};
        else if (sh < SMIN)
            rescale = {1'b1, SMIN[NBITS-1:0]};
        else
            rescale = {1'b0, sh[NBITS-1:0]};
    endfunction

    logic [CW-1:0] cnt;
    logic          primed;
    logic [AW-1:0] ptr;
    logic          phase_b;

    logic [WO-1:0] mem_re [DEPTH];
    logic [WO-1:0] mem_im [DEPTH];

    logic [NBITS:0] rs_re, rs_im;
    logic [WO-1:0]  x_re, x_im;
    logic [WO-1:0]  a_re, a_im;
    logic [WO-1:0]  out_re, out_im;
    logic [WO-1:0]  wr_re, wr_im;
    logic           clamp;

    // Delay-line slot is addressed by the low counter bits: read-then-write
    // of the same slot gives exactly DEPTH valid beats of delay.
    assign ptr     = cnt[AW-1:0];
    assign phase_b = cnt[CW-1];

    // Rescale and butterfly datapath.
    always_comb begin
        rs_re  = rescale(din[2*NBITS_in-1:NBITS_in]);
        rs_im  = rescale(din[NBITS_in-1:0]);
        clamp  = rs_re[NBITS] | rs_im[NBITS];
        x_re   = {rs_re[NBITS-1], rs_re[NBITS-1:0]};
        x_im   = {rs_im[NBITS-1], rs_im[NBITS-1:0]};
        a_re   = mem_re[ptr];
        a_im   = mem_im[ptr];
        out_re = a_re;
        out_im = a_im;
        wr_re  = x_re;
        wr_im  = x_im;
        if (phase_b) begin
            out_re = a_re + x_re;
            out_im = a_im + x_im;
            wr_re  = a_re - x_re;
            wr_im  = a_im - x_im;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            dout      <= '0;
            valid_out <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (valid_in) begin
            cnt       <= cnt + CW'(1);
            dout      <= {out_re, out_im};
            valid_out <= phase_b | primed;
            if (phase_b)
                primed <= 1'b1;
            if (clamp)
                sat_flag <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

    // Delay-line storage; contents are not reset, primed masks stale words.
    always_ff @(posedge clk) begin
        if (valid_in && rst) begin
            mem_re[ptr] <= wr_re;
            mem_im[ptr] <= wr_im;
        end
    end

endmodule
